loop_scan_engine: RTL and testbench

- Parametrised multi-cycle table search engine with early-exit control flow: first-match exit (break), per-entry skip (continue), iteration limit (repeat), external abort (disable), and at-least-one-iteration semantics (do-while).
- Sits beside the control-flow test modules as the clocked, handshaked generalisation: a loaded table is scanned LANES entries per cycle.

---
 rtl/loop_scan_pkg.sv | 38 +++
 rtl/loop_scan_window.sv | 86 ++++++++
 rtl/loop_scan_engine.sv | 186 ++++++++++++++++++
 tb/tb_loop_scan_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_scan_pkg.sv
// rtl/loop_scan_pkg.sv - shared types and helpers for the loop scan engine
// Purpose: scan FSM state encoding, result record and limit normalisation.
// Ports: none (package).
package loop_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Result record is sized for the largest supported table; users slice
    // the low bits that match their own DEPTH.
    localparam int SCAN_MAX_DEPTH = 256;
    localparam int RES_IW         = idx_w(SCAN_MAX_DEPTH);
    localparam int RES_CW         = cnt_w(SCAN_MAX_DEPTH);

    typedef struct packed {
        logic              found;
        logic [RES_IW-1:0] idx;
        logic [RES_CW-1:0] count;
        logic              aborted;
    } scan_result_t;

    // A zero or oversized limit means "scan the whole table".
    function automatic int eff_limit(input int lim, input int depth);
        return ((lim == 0) || (lim > depth)) ? depth : lim;
    endfunction

endpackage

// File: rtl/loop_scan_window.sv
// rtl/loop_scan_window.sv - combinational evaluation of one LANES-wide scan window
// Purpose: walk entries ptr..ptr+LANES-1, skipping masked ones, counting the
//          compared ones, and report the first hit or a stop condition.
// Ports: tbl_flat (whole table), key, skip_bits (whole mask), ptr (window base),
//        count/limit (compare budget) -> hit, hit_idx, new_count, stop.
module loop_scan_window #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int LANES = 2,
    parameter int IW    = 3,
    parameter int CW    = 4
) (
    input  logic [DEPTH*WIDTH-1:0] tbl_flat,
    input  logic [WIDTH-1:0]       key,
    input  logic [DEPTH-1:0]       skip_bits,
    input  logic [IW-1:0]          ptr,
    input  logic [CW-1:0]          count,
    input  logic [CW-1:0]          limit,
    output logic                   hit,
    output logic [IW-1:0]          hit_idx,
    output logic [CW-1:0]          new_count,
    output logic                   stop
);

    typedef struct packed {
        logic          hit;
        logic [IW-1:0] idx;
        logic [CW-1:0] cnt;
        logic          stop;
    } win_t;

    function automatic win_t eval_window(
        input logic [DEPTH*WIDTH-1:0] t,
        input logic [WIDTH-1:0]       k,
        input logic [DEPTH-1:0]       s,
        input int                     p,
        input int                     c_in,
        input int                     lim
    );
        win_t r;
        int   c;
        logic live;
        r    = '0;
        c    = c_in;
        live = 1'b0;
        // Constant loop bounds keep every table select static.
        for (int j = 0; j < DEPTH; j++) begin
            if (j < p) continue;
            if (j >= p + LANES) break;
            if (s[j]) continue;
            c++;
            if (t[j*WIDTH +: WIDTH] == k) begin
                r.hit  = 1'b1;
                r.idx  = IW'(j);
                r.cnt  = CW'(c);
                r.stop = 1'b1;
                return r;
            end
            if (c >= lim) begin
                r.cnt  = CW'(c);
                r.stop = 1'b1;
                return r;
            end
        end
        // Nothing compare-able beyond this window: end now rather than spin
        // through windows that are fully skipped or past the table end.
        for (int j = 0; j < DEPTH; j++) begin
            if ((j >= p + LANES) && !s[j]) live = 1'b1;
        end
        r.cnt  = CW'(c);
        r.stop = !live;
        return r;
    endfunction

    win_t w;

    always_comb begin
        w = eval_window(tbl_flat, key, skip_bits, int'(ptr), int'(count), int'(limit));
    end

    assign hit       = w.hit;
    assign hit_idx   = w.idx;
    assign new_count = w.cnt;
    assign stop      = w.stop;

endmodule

// File: rtl/loop_scan_engine.sv
// rtl/loop_scan_engine.sv - handshaked multi-cycle table search with early exit
// Purpose: holds a DEPTH-entry table and scans it LANES entries per cycle for a
//          key, honouring skip mask, compare limit and abort.
// Ports: clk, rst_n (async active-low); wr_en/wr_idx/wr_data table write;
//        start_valid/start_ready + key/skip_mask/limit request;
//        abort; res_valid/res_ready + res_found/res_idx/res_count/res_aborted.
// Option: LOOP_SCAN_PERF_EN adds perf_cycles (saturating count of SCAN cycles).
module loop_scan_engine
    import loop_scan_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    parameter  int LANES = 2,
    localparam int IW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] key,
    input  logic [DEPTH-1:0] skip_mask,
    input  logic [CW-1:0]    limit,
    input  logic             abort,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_found,
    output logic [IW-1:0]    res_idx,
    output logic [CW-1:0]    res_count,
    output logic             res_aborted
`ifdef LOOP_SCAN_PERF_EN
    ,
    output logic [15:0]      perf_cycles
`endif
);

    scan_state_e            state_q, state_d;
    logic [DEPTH*WIDTH-1:0] tbl_q, tbl_d;
    logic [WIDTH-1:0]       key_q, key_d;
    logic [DEPTH-1:0]       skip_q, skip_d;
    logic [CW-1:0]          lim_q, lim_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    scan_result_t           res_q, res_d;
    logic                   res_valid_q, res_valid_d;
`ifdef LOOP_SCAN_PERF_EN
    logic [15:0]            perf_q, perf_d;
`endif

    logic          win_hit;
    logic [IW-1:0] win_idx;
    logic [CW-1:0] win_cnt;
    logic          win_stop;

    loop_scan_window #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LANES (LANES),
        .IW    (IW),
        .CW    (CW)
    ) u_window (
        .tbl_flat  (tbl_q),
        .key       (key_q),
        .skip_bits (skip_q),
        .ptr       (ptr_q),
        .count     (cnt_q),
        .limit     (lim_q),
        .hit       (win_hit),
        .hit_idx   (win_idx),
        .new_count (win_cnt),
        .stop      (win_stop)
    );

    always_comb begin
        state_d     = state_q;
        tbl_d       = tbl_q;
        key_d       = key_q;
        skip_d      = skip_q;
        lim_d       = lim_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
`ifdef LOOP_SCAN_PERF_EN
        perf_d      = perf_q;
        if ((state_q == SCAN) && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
`endif

        // Table is frozen while a search runs; an IDLE write lands in the same
        // edge as an accept, so the first window already sees it.
        if (wr_en && (state_q != SCAN)) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (wr_idx == IW'(j)) tbl_d[j*WIDTH +: WIDTH] = wr_data;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    key_d   = key;
                    skip_d  = skip_mask;
                    lim_d   = CW'(eff_limit(int'(limit), DEPTH));
                    ptr_d   = '0;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    // This cycle's window is discarded, so report the
                    // count accumulated by earlier windows only.
                    res_d                = '0;
                    res_d.count[CW-1:0]  = cnt_q;
                    res_d.aborted        = 1'b1;
                    res_valid_d          = 1'b1;
                    state_d              = DONE;
                end else if (win_stop) begin
                    res_d                = '0;
                    res_d.found          = win_hit;
                    res_d.idx[IW-1:0]    = win_idx;
                    res_d.count[CW-1:0]  = win_cnt;
                    res_valid_d          = 1'b1;
                    state_d              = DONE;
                end else begin
                    ptr_d = ptr_q + IW'(LANES);
                    cnt_d = win_cnt;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tbl_q       <= '0;
            key_q       <= '0;
            skip_q      <= '0;
            lim_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
`ifdef LOOP_SCAN_PERF_EN
            perf_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tbl_q       <= tbl_d;
            key_q       <= key_d;
            skip_q      <= skip_d;
            lim_q       <= lim_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
`ifdef LOOP_SCAN_PERF_EN
            perf_q      <= perf_d;
`endif
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = res_valid_q;
    assign res_found   = res_q.found;
    assign res_idx     = res_q.idx[IW-1:0];
    assign res_count   = res_q.count[CW-1:0];
    assign res_aborted = res_q.aborted;
`ifdef LOOP_SCAN_PERF_EN
    assign perf_cycles = perf_q;
`endif

    // Upper bits of the shared result record are always zero for this DEPTH.
    logic unused_res_bits;
    assign unused_res_bits = ^{res_q.idx, res_q.count};

endmodule

// File: tb/tb_loop_scan_engine.sv
// tb/tb_loop_scan_engine.sv - self-checking bench for loop_scan_engine
module tb_loop_scan_engine;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int LANES = 2;
    localparam int IW    = 3;
    localparam int CW    = 4;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [IW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] key;
    logic [DEPTH-1:0] skip_mask;
    logic [CW-1:0]    limit;
    logic             abort;
    logic             res_valid;
    logic             res_ready;
    logic             res_found;
    logic [IW-1:0]    res_idx;
    logic [CW-1:0]    res_count;
    logic             res_aborted;
`ifdef LOOP_SCAN_PERF_EN
    logic [15:0]      perf_cycles;
    int               perf_exp;
`endif

    loop_scan_engine #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LANES (LANES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .key         (key),
        .skip_mask   (skip_mask),
        .limit       (limit),
        .abort       (abort),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_found   (res_found),
        .res_idx     (res_idx),
        .res_count   (res_count),
        .res_aborted (res_aborted)
`ifdef LOOP_SCAN_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] key;
        logic [DEPTH-1:0] skip;
        logic [CW-1:0]    lim;
        int               abort_at;
        int               wr_phase;
        logic [IW-1:0]    widx;
        logic [WIDTH-1:0] wdata;
        int               hold;
        logic             e_found;
        logic [IW-1:0]    e_idx;
        logic [CW-1:0]    e_count;
        logic             e_abort;
        int               e_lat;
    } vec_t;

    typedef struct {
        logic          found;
        logic [IW-1:0] idx;
        logic [CW-1:0] count;
        logic          aborted;
        int            lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    vec_t post[2];

    task automatic run(input vec_t v);
        exp_t e;
        int   lat;
        bit   got;
        @(negedge clk);
        check("start_ready_idle", start_ready, 1);
        start_valid = 1'b1;
        key         = v.key;
        skip_mask   = v.skip;
        limit       = v.lim;
        if (v.wr_phase == 1) begin
            wr_en   = 1'b1;
            wr_idx  = v.widx;
            wr_data = v.wdata;
        end
        @(posedge clk);
        sb.push_back('{v.e_found, v.e_idx, v.e_count, v.e_abort, v.e_lat});
        #1;
        start_valid = 1'b0;
        wr_en       = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            abort = (v.abort_at == lat + 1);
            if (v.wr_phase == 2 && lat == 0) begin
                wr_en   = 1'b1;
                wr_idx  = v.widx;
                wr_data = v.wdata;
            end
            @(posedge clk);
            #1;
            lat++;
            abort = 1'b0;
            wr_en = 1'b0;
            if (res_valid) got = 1'b1;
        end
        check("res_valid_seen", 32'(got), 1);
        e = sb.pop_front();
        if (got) begin
`ifdef LOOP_SCAN_PERF_EN
            perf_exp += lat;
`endif
            check("latency", lat, e.lat);
            check("res_found", res_found, e.found);
            check("res_idx", res_idx, e.idx);
            check("res_count", res_count, e.count);
            check("res_aborted", res_aborted, e.aborted);
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                check("hold_valid", res_valid, 1);
                check("hold_start_ready", start_ready, 0);
                check("hold_found", res_found, e.found);
                check("hold_idx", res_idx, e.idx);
                check("hold_count", res_count, e.count);
            end
            @(negedge clk);
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
            check("valid_drop", res_valid, 0);
            check("back_to_idle", start_ready, 1);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = '0;
        wr_data     = '0;
        start_valid = 1'b0;
        key         = '0;
        skip_mask   = '0;
        limit       = '0;
        abort       = 1'b0;
        res_ready   = 1'b0;
`ifdef LOOP_SCAN_PERF_EN
        perf_exp    = 0;
`endif

        //           key     skip   lim  ab wr widx  wdata  hold fnd idx  cnt  abt lat
        vecs[0]  = '{8'd9,   8'h00, 4'd0, 0, 0, 3'd0, 8'h00, 5, 1'b1, 3'd3, 4'd4, 1'b0, 2};
        vecs[1]  = '{8'd9,   8'h08, 4'd0, 0, 0, 3'd0, 8'h00, 0, 1'b0, 3'd0, 4'd7, 1'b0, 4};
        vecs[2]  = '{8'd21,  8'h00, 4'd3, 0, 0, 3'd0, 8'h00, 0, 1'b0, 3'd0, 4'd3, 1'b0, 2};
        vecs[3]  = '{8'd0,   8'hFF, 4'd0, 0, 0, 3'd0, 8'h00, 0, 1'b0, 3'd0, 4'd0, 1'b0, 1};
        vecs[4]  = '{8'd21,  8'h00, 4'd0, 2, 0, 3'd0, 8'h00, 0, 1'b0, 3'd0, 4'd2, 1'b1, 2};
        vecs[5]  = '{8'd21,  8'h00, 4'd0, 0, 0, 3'd0, 8'h00, 0, 1'b1, 3'd7, 4'd8, 1'b0, 4};
        vecs[6]  = '{8'd0,   8'h00, 4'd0, 0, 0, 3'd0, 8'h00, 0, 1'b1, 3'd0, 4'd1, 1'b0, 1};
        vecs[7]  = '{8'd18,  8'h41, 4'd0, 0, 0, 3'd0, 8'h00, 0, 1'b0, 3'd0, 4'd6, 1'b0, 4};
        vecs[8]  = '{8'd15,  8'h00, 4'd9, 0, 0, 3'd0, 8'h00, 0, 1'b1, 3'd5, 4'd6, 1'b0, 3};
        vecs[9]  = '{8'd12,  8'hE0, 4'd0, 0, 0, 3'd0, 8'h00, 0, 1'b1, 3'd4, 4'd5, 1'b0, 3};
        vecs[10] = '{8'd100, 8'hFC, 4'd0, 0, 0, 3'd0, 8'h00, 0, 1'b0, 3'd0, 4'd2, 1'b0, 1};
        vecs[11] = '{8'd6,   8'h00, 4'd3, 0, 0, 3'd0, 8'h00, 0, 1'b1, 3'd2, 4'd3, 1'b0, 2};
        vecs[12] = '{8'h77,  8'h00, 4'd0, 0, 1, 3'd7, 8'h77, 0, 1'b1, 3'd7, 4'd8, 1'b0, 4};
        vecs[13] = '{8'd21,  8'h00, 4'd0, 0, 0, 3'd0, 8'h00, 0, 1'b0, 3'd0, 4'd8, 1'b0, 4};
        vecs[14] = '{8'h55,  8'h00, 4'd0, 0, 2, 3'd0, 8'h55, 0, 1'b0, 3'd0, 4'd8, 1'b0, 4};
        vecs[15] = '{8'd0,   8'h00, 4'd0, 0, 0, 3'd0, 8'h00, 0, 1'b1, 3'd0, 4'd1, 1'b0, 1};
        // After reset the table is all zero.
        post[0]  = '{8'd9,   8'h00, 4'd0, 0, 0, 3'd0, 8'h00, 0, 1'b0, 3'd0, 4'd8, 1'b0, 4};
        post[1]  = '{8'd0,   8'h00, 4'd0, 0, 0, 3'd0, 8'h00, 0, 1'b1, 3'd0, 4'd1, 1'b0, 1};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_start_ready", start_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_found", res_found, 0);
        check("rst_res_idx", res_idx, 0);
        check("rst_res_count", res_count, 0);
        check("rst_res_aborted", res_aborted, 0);

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_idx  = IW'(i);
            wr_data = WIDTH'(i * 3);
        end
        @(negedge clk);
        wr_en = 1'b0;

        for (int i = 0; i < 16; i++) run(vecs[i]);

        // Reset in the middle of a scan: no result, outputs cleared.
        @(negedge clk);
        start_valid = 1'b1;
        key         = 8'd21;
        skip_mask   = '0;
        limit       = '0;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_start_ready", start_ready, 1);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_res_found", res_found, 0);
        check("midrst_res_idx", res_idx, 0);
        check("midrst_res_count", res_count, 0);
        check("midrst_res_aborted", res_aborted, 0);
`ifdef LOOP_SCAN_PERF_EN
        check("midrst_perf", perf_cycles, 0);
        perf_exp = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_no_result", res_valid, 0);

        for (int i = 0; i < 2; i++) run(post[i]);

`ifdef LOOP_SCAN_PERF_EN
        check("perf_cycles", perf_cycles, 32'(perf_exp));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
